// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the time display scanner.
//   NUM_DIGITS    : number of multiplexed digit slots (hh:mm:ss)
//   SEG_*         : 7-bit active-high segment glyphs, bit order {g,f,e,d,c,b,a}
//   slot_idx_t    : index of the currently scanned digit slot
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef logic [2:0] slot_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder.
//   nibble_i : 4-bit value; 0-9 map to digit glyphs, A-F to a dash
//   seg_o    : active-high segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// Scans a BCD hh:mm:ss time word onto a six-digit common-anode 7-segment display.
// The time word is captured once per scan frame so a frame never mixes digits
// from two different seconds. Each digit slot starts with one dark guard cycle
// to avoid ghosting when the digit enable moves.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   time_bcd   : {Ht,Hu,Mt,Mu,St,Su} BCD nibbles
//   colon_en   : light DP on the Mu and Hu digits
//   blank      : force all digits dark (scanning continues)
//   dig_n      : active-low digit enables, bit i = slot i
//   seg_n      : active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done : one-cycle pulse after the last slot of a frame ends
module time_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic        colon_en,
    input  logic        blank,
    output logic [5:0]  dig_n,
    output logic [7:0]  seg_n,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam slot_idx_t        SLOT_LAST = slot_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    slot_idx_t        idx_q, idx_d;
    logic [23:0]      snap_q, snap_d;
    logic [5:0]       dig_n_q, dig_n_d;
    logic [7:0]       seg_n_q, seg_n_d;
    logic             frame_done_q, frame_done_d;

    logic             div_wrap;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       seg_on;
    logic             dp;
    logic             dark;

    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign frame_end = div_wrap && (idx_q == SLOT_LAST);

    // Prescaler, slot counter and per-frame snapshot.
    always_comb begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (div_wrap) begin
            idx_d = frame_end ? slot_idx_t'(0) : slot_idx_t'(idx_q + 3'd1);
        end
        snap_d = frame_end ? time_bcd : snap_q;
    end

    always_comb begin
        nibble = 4'h0;
        case (idx_q)
            3'd0:    nibble = snap_q[3:0];
            3'd1:    nibble = snap_q[7:4];
            3'd2:    nibble = snap_q[11:8];
            3'd3:    nibble = snap_q[15:12];
            3'd4:    nibble = snap_q[19:16];
            3'd5:    nibble = snap_q[23:20];
            default: nibble = 4'h0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_on)
    );

    // Colon DP sits on the units digits of minutes and hours.
    assign dp = colon_en && ((idx_q == 3'd2) || (idx_q == 3'd4));

    // A leading-zero hours digit reuses the guard path so slot timing is untouched.
    assign dark = (div_cnt_q == '0) || blank ||
                  (LZ_BLANK && (idx_q == SLOT_LAST) && (snap_q[23:20] == 4'h0));

    always_comb begin
        dig_n_d      = dark ? 6'h3F : ~(6'b000001 << idx_q);
        seg_n_d      = dark ? 8'hFF : ~{dp, seg_on};
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            snap_q       <= 24'h000000;
            dig_n_q      <= 6'h3F;
            seg_n_q      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            dig_n_q      <= dig_n_d;
            seg_n_q      <= seg_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dig_n      = dig_n_q;
    assign seg_n      = seg_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan with SCAN_DIV=4. Two instances run
// side by side, one with leading-zero blanking and one without. A reference
// model derives the expected display from the cycle position inside a frame.
module tb_time_display_scan;

    localparam int D     = 4;
    localparam int FRAME = 6 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] time_bcd = 24'h0;
    logic        colon_en = 1'b0;
    logic        blank = 1'b0;

    logic [5:0]  dig_n_lz, dig_n_nz;
    logic [7:0]  seg_n_lz, seg_n_nz;
    logic        fd_lz, fd_nz;

    always #5 clk = ~clk;

    time_display_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b1)) u_lz (
        .clk(clk), .rst(rst), .time_bcd(time_bcd), .colon_en(colon_en), .blank(blank),
        .dig_n(dig_n_lz), .seg_n(seg_n_lz), .frame_done(fd_lz)
    );

    time_display_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b0)) u_nz (
        .clk(clk), .rst(rst), .time_bcd(time_bcd), .colon_en(colon_en), .blank(blank),
        .dig_n(dig_n_nz), .seg_n(seg_n_nz), .frame_done(fd_nz)
    );

    typedef struct {
        logic [5:0] dig_lz;
        logic [7:0] seg_lz;
        logic [5:0] dig_nz;
        logic [7:0] seg_nz;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since reset release and the captured time.
    int          cyc_m = 0;
    logic [23:0] snap_m = 24'h0;
    int          p_m, slot_m, phase_m;
    logic [3:0]  digit_m;
    logic        lit_m;
    logic [7:0]  seg_m;
    exp_t        e_m;
    exp_t        e_mon;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e_m.dig_lz = 6'h3F; e_m.seg_lz = 8'hFF;
            e_m.dig_nz = 6'h3F; e_m.seg_nz = 8'hFF;
            e_m.fd     = 1'b0;
            cyc_m  = 0;
            snap_m = 24'h0;
        end else begin
            p_m     = cyc_m % FRAME;
            slot_m  = p_m / D;
            phase_m = p_m % D;
            digit_m = snap_m[slot_m*4 +: 4];
            lit_m   = (phase_m != 0) && !blank;
            seg_m   = ~{colon_en && (slot_m == 2 || slot_m == 4), glyph(digit_m)};
            e_m.fd  = (p_m == FRAME - 1);
            e_m.dig_nz = lit_m ? ~(6'b000001 << slot_m) : 6'h3F;
            e_m.seg_nz = lit_m ? seg_m : 8'hFF;
            if (lit_m && !(slot_m == 5 && digit_m == 4'h0)) begin
                e_m.dig_lz = ~(6'b000001 << slot_m);
                e_m.seg_lz = seg_m;
            end else begin
                e_m.dig_lz = 6'h3F;
                e_m.seg_lz = 8'hFF;
            end
            if (p_m == FRAME - 1) snap_m = time_bcd;
            cyc_m = cyc_m + 1;
        end
        exp_q.push_back(e_m);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            check("dig_n_lz", {2'b00, dig_n_lz}, {2'b00, e_mon.dig_lz});
            check("seg_n_lz", seg_n_lz, e_mon.seg_lz);
            check("dig_n_nz", {2'b00, dig_n_nz}, {2'b00, e_mon.dig_nz});
            check("seg_n_nz", seg_n_nz, e_mon.seg_nz);
            check("frame_done_lz", {7'b0, fd_lz}, {7'b0, e_mon.fd});
            check("frame_done_nz", {7'b0, fd_nz}, {7'b0, e_mon.fd});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset release with a time already present: first frame shows zeros.
        rst = 1'b1; time_bcd = 24'h123456;
        tick(3);
        rst = 1'b0;
        tick(2 * FRAME + 5);

        // Time rolls over mid-frame; only the frame edge may pick it up.
        time_bcd = 24'h095959;
        tick(FRAME);
        tick(10);
        time_bcd = 24'h100000;
        tick(2 * FRAME);

        // Non-BCD nibbles become dashes, colon DP on Mu/Hu, zero hours tens.
        colon_en = 1'b1; time_bcd = 24'h0A0F00;
        tick(2 * FRAME);

        // Blank toggled mid-slot.
        tick(6);
        blank = 1'b1; tick(3);
        blank = 1'b0; tick(FRAME);
        blank = 1'b1; tick(1);
        blank = 1'b0; tick(FRAME);

        // One-cycle reset in the middle of slot 3.
        for (int i = 0; i < FRAME && (cyc_m % FRAME) != 3 * D + 1; i++) tick(1);
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(2 * FRAME);

        // Random traffic, half of the time words valid BCD.
        repeat (900) begin
            if ($urandom_range(0, 1) == 1) begin
                time_bcd = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end else begin
                time_bcd = 24'($urandom);
            end
            colon_en = 1'($urandom_range(0, 1));
            blank    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; blank = 1'b0;
        tick(FRAME);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
